// File: rtl/frame_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : frame_scheduler_pkg
//  Purpose  : Shared types and defaults for the frame scheduler and the
//             pulse generator that feeds it, so both agree on the frame budget.
//  Revision : 1.0 - initial release
// ============================================================================
package frame_scheduler_pkg;

    // Default number of sequenced stages: input capture, physics, render
    localparam int unsigned c_DEFAULT_STAGES         = 3;
    // Default per-stage watchdog budget in clock cycles
    localparam int unsigned c_DEFAULT_TIMEOUT_CYCLES = 1000000;

    // Sequencer phase; the stage being serviced lives in its own register
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } sched_state_t;

    // Bit width needed to index v items, never less than one bit
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage : frame_scheduler_pkg
`default_nettype wire

// File: rtl/frame_scheduler_stage_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : frame_scheduler_stage_watchdog
//  Purpose  : Up-counter of WAIT cycles with clear; flags the cycle in which
//             the wait budget is used up. TIMEOUT_CYCLES = 0 disables it.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_scheduler_stage_watchdog
    import frame_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int unsigned CNT_WIDTH = clog2_min1(TIMEOUT_CYCLES + 1);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_enabled
            localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

            logic [CNT_WIDTH-1:0] r_count;

            // Count completed WAIT cycles; hold at the last value so it cannot wrap
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count <= '0;
                end else if (i_clear) begin
                    r_count <= '0;
                end else if (i_count && (r_count != c_LAST)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Expiry is the TIMEOUT_CYCLES-th WAIT cycle itself, so a done in
            // that same cycle can still be honoured by the caller
            assign o_expired = i_count && (r_count == c_LAST);
        end else begin : g_disabled
            assign o_expired = 1'b0;
        end
    endgenerate

endmodule : frame_scheduler_stage_watchdog
`default_nettype wire

// File: rtl/frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : frame_scheduler
//  Purpose  : On each accepted frame tick, launches STAGES downstream units
//             in order with start/done handshakes. Counts completed frames,
//             counts ticks that arrive while busy (one-deep pending relaunch)
//             and flags a stage that fails to answer within the watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int unsigned  STAGES         = c_DEFAULT_STAGES,
    parameter int unsigned  FRAME_WIDTH    = 16,
    parameter int unsigned  OVR_WIDTH      = 8,
    parameter int unsigned  TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES,
    localparam int unsigned STAGE_W        = clog2_min1(STAGES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   enable,
    input  logic [STAGES-1:0]      done,
    input  logic                   clear_err,
    output logic [STAGES-1:0]      start,
    output logic                   busy,
    output logic [FRAME_WIDTH-1:0] frame_count,
    output logic [OVR_WIDTH-1:0]   overrun_count,
    output logic                   timeout_err,
    output logic [STAGE_W-1:0]     err_stage
);

    sched_state_t           r_state;
    logic [STAGE_W-1:0]     r_stage;
    logic                   r_pending;
    logic [STAGES-1:0]      r_start;
    logic                   r_busy;
    logic [FRAME_WIDTH-1:0] r_frame_count;
    logic [OVR_WIDTH-1:0]   r_overrun_count;
    logic                   r_timeout_err;
    logic [STAGE_W-1:0]     r_err_stage;

    logic                   w_req;
    logic [STAGES-1:0]      w_stage_sel;
    logic [STAGES-1:0]      w_next_start;
    logic                   w_stage_done;
    logic                   w_last_stage;
    logic                   w_wd_count;
    logic                   w_wd_clear;
    logic                   w_wd_expired;
    logic                   w_timeout;
    logic                   w_ovr_inc;

    // A tick only counts as a frame request while enabled
    assign w_req        = tick && enable;
    // Only the done bit of the stage being waited on is observed
    assign w_stage_sel  = STAGES'(1) << r_stage;
    assign w_next_start = STAGES'(1) << (r_stage + 1'b1);
    assign w_stage_done = (r_state == ST_WAIT) && |(done & w_stage_sel);
    assign w_last_stage = (r_stage == STAGE_W'(STAGES - 1));
    // Watchdog runs only in WAIT and restarts from zero for every stage
    assign w_wd_count   = (r_state == ST_WAIT);
    assign w_wd_clear   = (r_state != ST_WAIT);
    assign w_timeout    = w_wd_expired && !w_stage_done;
    // Overrun counter saturates at all-ones
    assign w_ovr_inc    = w_req && (r_state != ST_IDLE) && !(&r_overrun_count);

    frame_scheduler_stage_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clock),
        .rst       (reset),
        .i_clear   (w_wd_clear),
        .i_count   (w_wd_count),
        .o_expired (w_wd_expired)
    );

    // Frame sequencer with all outputs registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_stage         <= '0;
            r_pending       <= 1'b0;
            r_start         <= '0;
            r_busy          <= 1'b0;
            r_frame_count   <= '0;
            r_overrun_count <= '0;
            r_timeout_err   <= 1'b0;
            r_err_stage     <= '0;
        end else begin
            r_start <= '0;

            // Clear first so that a timeout later in this block overrides it
            if (clear_err) begin
                r_timeout_err <= 1'b0;
                r_err_stage   <= '0;
            end

            if (w_ovr_inc) begin
                r_overrun_count <= r_overrun_count + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state <= ST_LAUNCH;
                        r_stage <= '0;
                        r_start <= STAGES'(1);
                        r_busy  <= 1'b1;
                    end
                end

                ST_LAUNCH: begin
                    // done during the start cycle is deliberately ignored
                    r_state <= ST_WAIT;
                    if (w_req) begin
                        r_pending <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (w_stage_done) begin
                        if (!w_last_stage) begin
                            r_state <= ST_LAUNCH;
                            r_stage <= r_stage + 1'b1;
                            r_start <= w_next_start;
                            if (w_req) begin
                                r_pending <= 1'b1;
                            end
                        end else begin
                            r_frame_count <= r_frame_count + 1'b1;
                            if (r_pending || w_req) begin
                                // Relaunch consumes one request; a second
                                // coincident request stays pending
                                r_state   <= ST_LAUNCH;
                                r_stage   <= '0;
                                r_start   <= STAGES'(1);
                                r_pending <= r_pending && w_req;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_pending     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_err_stage   <= r_stage;
                    end else if (w_req) begin
                        r_pending <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign start         = r_start;
    assign busy          = r_busy;
    assign frame_count   = r_frame_count;
    assign overrun_count = r_overrun_count;
    assign timeout_err   = r_timeout_err;
    assign err_stage     = r_err_stage;

endmodule : frame_scheduler
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_frame_scheduler
//  Purpose  : Self-checking bench for frame_scheduler: directed scenarios plus
//             randomized traffic compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

    localparam int c_STAGES  = 3;
    localparam int c_TIMEOUT = 20;
    localparam int c_OVR_MAX = 255;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        tick      = 1'b0;
    logic        enable    = 1'b0;
    logic        clear_err = 1'b0;
    logic [2:0]  done_man  = '0;
    logic [2:0]  done_auto = '0;
    logic [2:0]  done;
    logic [2:0]  start;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;
    logic        timeout_err;
    logic [1:0]  err_stage;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder controls
    bit auto_en   = 1'b0;
    bit auto_rand = 1'b0;
    int auto_lo   = 2;
    int auto_hi   = 2;
    bit saw_idle  = 1'b0;

    assign done = done_man | done_auto;

    frame_scheduler #(
        .STAGES         (c_STAGES),
        .FRAME_WIDTH    (16),
        .OVR_WIDTH      (8),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .tick          (tick),
        .enable        (enable),
        .done          (done),
        .clear_err     (clear_err),
        .start         (start),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun_count (overrun_count),
        .timeout_err   (timeout_err),
        .err_stage     (err_stage)
    );

    initial forever #5 clock = ~clock;

    // ---------------- behavioural reference model ----------------
    int         m_k;       // stage in service, -1 when no frame is running
    bit         m_fresh;   // this is the start cycle of stage m_k
    int         m_waited;
    bit         m_pend;
    int         m_frames;
    int         m_ovr;
    bit         m_err;
    int         m_errk;
    logic [2:0] m_start;

    task automatic model_reset();
        m_k = -1; m_fresh = 0; m_waited = 0; m_pend = 0;
        m_frames = 0; m_ovr = 0; m_err = 0; m_errk = 0; m_start = '0;
    endtask

    task automatic model_step();
        bit req;
        bit new_err;
        req     = tick && enable;
        new_err = 0;
        if (m_k >= 0 && req) m_ovr = (m_ovr < c_OVR_MAX) ? m_ovr + 1 : c_OVR_MAX;
        if (m_k < 0) begin
            if (req) begin m_k = 0; m_fresh = 1; end
        end else if (m_fresh) begin
            m_fresh = 0; m_waited = 0;
            if (req) m_pend = 1;
        end else begin
            m_waited++;
            if (done[m_k]) begin
                if (m_k < c_STAGES - 1) begin
                    m_k++; m_fresh = 1;
                    if (req) m_pend = 1;
                end else begin
                    m_frames = (m_frames + 1) % 65536;
                    if (m_pend || req) begin
                        m_k = 0; m_fresh = 1; m_pend = m_pend && req;
                    end else begin
                        m_k = -1;
                    end
                end
            end else if (m_waited >= c_TIMEOUT) begin
                new_err = 1; m_errk = m_k; m_k = -1; m_pend = 0;
            end else if (req) begin
                m_pend = 1;
            end
        end
        if (clear_err) begin m_err = 0; if (!new_err) m_errk = 0; end
        if (new_err) m_err = 1;
        m_start = m_fresh ? 3'(1 << m_k) : 3'b000;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // ---------------- auto-responding stages ----------------
    function automatic int pick_delay();
        if (auto_rand && $urandom_range(0, 15) == 0) return 25;
        return $urandom_range(auto_lo, auto_hi);
    endfunction

    int rem [3];
    initial begin
        for (int k = 0; k < 3; k++) rem[k] = -1;
        forever begin
            @(posedge clock); #1;
            done_auto = '0;
            for (int k = 0; k < 3; k++) begin
                if (!auto_en || reset) begin
                    rem[k] = -1;
                end else begin
                    if (rem[k] > 0) rem[k]--;
                    if (rem[k] == 0) begin done_auto[k] = 1'b1; rem[k] = -1; end
                    if (start[k]) rem[k] = pick_delay();
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clock); #1;
        if (busy !== 1'b1) saw_idle = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 0; enable = 0; clear_err = 0; done_man = '0;
        auto_en = 0; auto_rand = 0;
        step(); step();
        reset = 1'b0;
    endtask

    // Called in the cycle where start[k] is visible; answers d cycles later
    task automatic run_stage(input int k, input int d);
        repeat (d) step();
        done_man[k] = 1'b1;
        step();
        done_man = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (start !== 3'b000) begin n_fail++; $display("FAIL reset_start: got %b want 000", start); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frames: got %0d want 0", frame_count); end
        n_checks++; if (overrun_count !== 8'd0) begin n_fail++; $display("FAIL reset_ovr: got %0d want 0", overrun_count); end
        n_checks++; if (timeout_err !== 1'b0 || err_stage !== 2'd0) begin n_fail++; $display("FAIL reset_err: got %b/%0d want 0/0", timeout_err, err_stage); end
    endtask

    task automatic test_basic_frame();
        logic [2:0] exp_s;
        do_reset();
        enable = 1'b1;
        repeat (9) step();
        tick = 1'b1; step(); tick = 1'b0;
        n_checks++; if (start !== 3'b001 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_start0: start=%b busy=%b want 001/1", start, busy); end
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL basic_frames_before: got %0d want 0", frame_count); end
            end
            run_stage(k, 5);
            if (k < 2) begin
                exp_s = 3'b001 << (k + 1);
                n_checks++; if (start !== exp_s) begin n_fail++; $display("FAIL basic_start%0d: got %b want %b", k + 1, start, exp_s); end
            end else begin
                n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL basic_frames_after: got %0d want 1", frame_count); end
                n_checks++; if (busy !== 1'b0 || start !== 3'b000) begin n_fail++; $display("FAIL basic_end: busy=%b start=%b want 0/000", busy, start); end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        enable = 1'b1;
        tick = 1'b1; step(); tick = 1'b0;
        saw_idle = 1'b0;
        run_stage(0, 2);
        step(); tick = 1'b1; step(); tick = 1'b0;
        run_stage(1, 3);
        tick = 1'b1; step(); tick = 1'b0;
        n_checks++; if (overrun_count !== 8'd2) begin n_fail++; $display("FAIL ovr_count: got %0d want 2", overrun_count); end
        run_stage(2, 3);
        n_checks++; if (start !== 3'b001 || busy !== 1'b1) begin n_fail++; $display("FAIL ovr_relaunch: start=%b busy=%b want 001/1", start, busy); end
        n_checks++; if (saw_idle !== 1'b0) begin n_fail++; $display("FAIL ovr_busy_drop: dropped=%b want 0", saw_idle); end
        n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL ovr_frames1: got %0d want 1", frame_count); end
        run_stage(0, 2); run_stage(1, 2); run_stage(2, 2);
        n_checks++; if (frame_count !== 16'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL ovr_frames2: frames=%0d busy=%b want 2/0", frame_count, busy); end
    endtask

    task automatic test_coincident();
        do_reset();
        enable = 1'b1;
        tick = 1'b1; step(); tick = 1'b0;
        run_stage(0, 2); run_stage(1, 2);
        step(); step();
        done_man = 3'b100; tick = 1'b1; step(); done_man = '0; tick = 1'b0;
        n_checks++; if (overrun_count !== 8'd1) begin n_fail++; $display("FAIL coin_ovr: got %0d want 1", overrun_count); end
        n_checks++; if (start !== 3'b001 || busy !== 1'b1) begin n_fail++; $display("FAIL coin_relaunch: start=%b busy=%b want 001/1", start, busy); end
        run_stage(0, 2); run_stage(1, 2); run_stage(2, 2);
        n_checks++; if (frame_count !== 16'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL coin_end: frames=%0d busy=%b want 2/0", frame_count, busy); end
    endtask

    task automatic test_saturation();
        do_reset();
        enable = 1'b1; auto_lo = 2; auto_hi = 2; auto_en = 1'b1;
        tick = 1'b1;
        repeat (200) step();
        n_checks++; if (overrun_count !== 8'd199) begin n_fail++; $display("FAIL sat_mid: got %0d want 199", overrun_count); end
        repeat (120) step();
        n_checks++; if (overrun_count !== 8'd255) begin n_fail++; $display("FAIL sat_top: got %0d want 255", overrun_count); end
        tick = 1'b0;
        repeat (30) step();
        n_checks++; if (overrun_count !== 8'd255 || busy !== 1'b0) begin n_fail++; $display("FAIL sat_hold: ovr=%0d busy=%b want 255/0", overrun_count, busy); end
        auto_en = 1'b0;
    endtask

    task automatic test_watchdog();
        do_reset();
        enable = 1'b1;
        tick = 1'b1; step(); tick = 1'b0;
        run_stage(0, 3);
        repeat (c_TIMEOUT) step();
        n_checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wd_early: err=%b busy=%b want 0/1", timeout_err, busy); end
        step();
        n_checks++; if (timeout_err !== 1'b1 || err_stage !== 2'd1) begin n_fail++; $display("FAIL wd_expire: err=%b stage=%0d want 1/1", timeout_err, err_stage); end
        n_checks++; if (busy !== 1'b0 || frame_count !== 16'd0) begin n_fail++; $display("FAIL wd_state: busy=%b frames=%0d want 0/0", busy, frame_count); end
        clear_err = 1'b1; step(); clear_err = 1'b0;
        n_checks++; if (timeout_err !== 1'b0 || err_stage !== 2'd0) begin n_fail++; $display("FAIL wd_clear: err=%b stage=%0d want 0/0", timeout_err, err_stage); end
        // done arriving in the expiry cycle itself must win
        tick = 1'b1; step(); tick = 1'b0;
        run_stage(0, c_TIMEOUT);
        n_checks++; if (timeout_err !== 1'b0 || start !== 3'b010) begin n_fail++; $display("FAIL wd_done_wins: err=%b start=%b want 0/010", timeout_err, start); end
        run_stage(1, 2); run_stage(2, 2);
        n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL wd_frames: got %0d want 1", frame_count); end
    endtask

    task automatic test_spurious();
        do_reset();
        enable = 1'b1;
        tick = 1'b1; step(); tick = 1'b0;
        done_man = 3'b001; step();
        n_checks++; if (start !== 3'b000) begin n_fail++; $display("FAIL spur_stale: start=%b want 000", start); end
        done_man = 3'b100; step(); done_man = '0;
        n_checks++; if (start !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL spur_other: start=%b busy=%b want 000/1", start, busy); end
        step();
        done_man = 3'b001; step(); done_man = '0;
        n_checks++; if (start !== 3'b010) begin n_fail++; $display("FAIL spur_advance: start=%b want 010", start); end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        tick = 1'b1; step(); step(); tick = 1'b0;
        run_stage(0, 1); run_stage(1, 1); run_stage(2, 1);
        run_stage(0, 1); step();
        n_checks++; if (frame_count !== 16'd1 || overrun_count !== 8'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre: frames=%0d ovr=%0d busy=%b want 1/1/1", frame_count, overrun_count, busy); end
        #3 reset = 1'b1;
        #1;
        n_checks++; if (start !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_ctl: start=%b busy=%b want 000/0", start, busy); end
        n_checks++; if (frame_count !== 16'd0 || overrun_count !== 8'd0) begin n_fail++; $display("FAIL arst_cnt: frames=%0d ovr=%0d want 0/0", frame_count, overrun_count); end
        n_checks++; if (timeout_err !== 1'b0 || err_stage !== 2'd0) begin n_fail++; $display("FAIL arst_err: err=%b stage=%0d want 0/0", timeout_err, err_stage); end
        @(posedge clock); #1 reset = 1'b0;
    endtask

    task automatic test_enable();
        bit saw_start;
        do_reset();
        saw_start = 1'b0;
        repeat (5) begin
            tick = 1'b1; step(); tick = 1'b0;
            if (start !== 3'b000) saw_start = 1'b1;
            step();
        end
        n_checks++; if (saw_start !== 1'b0 || busy !== 1'b0 || overrun_count !== 8'd0) begin n_fail++; $display("FAIL en_off: start_seen=%b busy=%b ovr=%0d want 0/0/0", saw_start, busy, overrun_count); end
        enable = 1'b1; tick = 1'b1; step(); tick = 1'b0; enable = 1'b0;
        n_checks++; if (start !== 3'b001) begin n_fail++; $display("FAIL en_launch: start=%b want 001", start); end
        run_stage(0, 2);
        tick = 1'b1; step(); tick = 1'b0;
        run_stage(1, 2); run_stage(2, 2);
        n_checks++; if (frame_count !== 16'd1 || busy !== 1'b0 || overrun_count !== 8'd0) begin n_fail++; $display("FAIL en_drop: frames=%0d busy=%b ovr=%0d want 1/0/0", frame_count, busy, overrun_count); end
    endtask

    task automatic test_random();
        logic exp_busy;
        do_reset();
        auto_lo = 1; auto_hi = 6; auto_rand = 1'b1; auto_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick      = ($urandom_range(0, 9) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            clear_err = ($urandom_range(0, 49) == 0);
            done_man  = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
            step();
            exp_busy = (m_k >= 0);
            n_checks++; if (start !== m_start) begin n_fail++; $display("FAIL rnd_start @%0d: got %b want %b", i, start, m_start); end
            n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", i, busy, exp_busy); end
            n_checks++; if (frame_count !== 16'(m_frames)) begin n_fail++; $display("FAIL rnd_frames @%0d: got %0d want %0d", i, frame_count, m_frames); end
            n_checks++; if (overrun_count !== 8'(m_ovr)) begin n_fail++; $display("FAIL rnd_ovr @%0d: got %0d want %0d", i, overrun_count, m_ovr); end
            n_checks++; if (timeout_err !== m_err) begin n_fail++; $display("FAIL rnd_err @%0d: got %b want %b", i, timeout_err, m_err); end
            n_checks++; if (err_stage !== 2'(m_errk)) begin n_fail++; $display("FAIL rnd_err_stage @%0d: got %0d want %0d", i, err_stage, m_errk); end
        end
        tick = 1'b0; clear_err = 1'b0; done_man = '0; auto_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overrun();
        test_coincident();
        test_saturation();
        test_watchdog();
        test_spurious();
        test_async_reset();
        test_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_frame_scheduler
`default_nettype wire

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Consumes the periodic single-cycle tick from the pulse generator (one tick per frame period).
- Sequences one frame of work through STAGES downstream units in a fixed order: input capture, physics, render.
- Handshake per stage: one-cycle start pulse out, done pulse back.
- Also provides: frame counter, saturating overrun counter (tick arrived while busy), per-stage watchdog timeout.

Parameters:
STAGES, 3, number of sequenced stages (1..8); stage 0 starts first
FRAME_WIDTH, 16, width of frame_count
OVR_WIDTH, 8, width of overrun_count
TIMEOUT_CYCLES, 1000000, max cycles to wait for a stage's done; 0 disables the watchdog

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  single-cycle frame tick from the pulse generator
enable  input  1  1 = accept ticks; 0 = ignore ticks (an in-flight frame still completes)
done  input  STAGES  done[k] is a one-cycle pulse from stage k
clear_err  input  1  clears timeout_err and err_stage
start  output  STAGES  one-hot, one-cycle start pulse to stage k
busy  output  1  high from the first start until the frame ends
frame_count  output  FRAME_WIDTH  completed frames; wraps modulo 2^FRAME_WIDTH
overrun_count  output  OVR_WIDTH  ticks received while busy; saturates at all-ones
timeout_err  output  1  sticky; set on a watchdog expiry
err_stage  output  $clog2(STAGES) (min 1)  stage index that timed out

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; pending flag cleared; watchdog counter 0. Takes effect mid-frame, with no completion and no count.
- All outputs are registered.
- States:
  - IDLE
  - LAUNCH(k): start[k]=1 for exactly one cycle.
  - WAIT(k)
- IDLE:
  - tick && enable at cycle t -> LAUNCH(0); start[0]=1 and busy=1 in cycle t+1.
- LAUNCH(k) -> WAIT(k) unconditionally next cycle; watchdog counter cleared.
- WAIT(k):
  - done[k] sampled at cycle t with k<STAGES-1 -> start[k+1]=1 at t+1.
  - done[k] at cycle t with k=STAGES-1 -> frame_count+1 at t+1.
    - If pending is set: pending cleared, go to LAUNCH(0); start[0]=1 at t+1, busy stays 1.
    - Otherwise go to IDLE; busy=0 at t+1.
- done bits for any stage other than the one being waited on are ignored, as is done[k] arriving during LAUNCH(k).
- done[k] in the same cycle as start[k] is not accepted. A stage needs at least one cycle.
- Overrun:
  - tick && enable while not in IDLE, including a tick coincident with the final done -> overrun_count+1 (saturating), pending=1.
  - Pending is one deep; further ticks still increment overrun_count.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without done[k] -> timeout_err=1, err_stage=k, pending cleared, go to IDLE; busy=0 next cycle; frame_count unchanged.
  - A done[k] in the expiry cycle wins: no error.
- timeout_err is sticky until clear_err or reset.
  - clear_err takes effect in the next cycle.
  - A simultaneous new timeout wins over clear_err.
  - Ticks are still accepted while timeout_err=1.
- enable=0 does not abort a frame. It blocks new frames and pending setting.

Decomposition:
- Shared package holds:
  - State encoding enum (IDLE/LAUNCH/WAIT) with the stage index held in a separate register.
  - Default STAGES and TIMEOUT_CYCLES constants, so the top level and the pulse generator instance agree on the frame budget.
- One natural sub-module: stage_watchdog, a loadable up-counter with clear and an expired flag, width $clog2(TIMEOUT_CYCLES+1).
- Saturating overrun counter is inline.

Test Plan:
- Basic frame:
  - Stimulus: reset, enable=1, tick at cycle 10; each stage returns done 5 cycles after its start.
  - Required: start[0]@11, start[1]@17, start[2]@23; frame_count 0->1 and busy=0 one cycle after done[2].
- Overrun:
  - Stimulus: two ticks during one frame, then frame completes.
  - Required: overrun_count=2; start[0] the cycle after the final done; busy never drops; frame_count=1, then 2 after the second frame.
- Coincident tick and final done:
  - Required: overrun_count+1, immediate relaunch.
  - Stimulus: 300 overruns with OVR_WIDTH=8.
  - Required: overrun_count saturates at 255.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=20, stage 1 never responds.
  - Required: timeout_err=1 and err_stage=1 exactly 20 WAIT cycles after start[1]; busy=0; frame_count unchanged.
  - Stimulus: clear_err pulse.
  - Required: timeout_err=0.
- Spurious and stale done:
  - Stimulus: done[2] while waiting on stage 0; done[0] in the same cycle as start[0].
  - Required: both ignored; the sequence still advances only on a correct done[0].
- Reset and enable:
  - Stimulus: async reset asserted mid-WAIT(1), between clock edges.
  - Required: all outputs 0 immediately.
  - Stimulus: enable=0 with ticks applied.
  - Required: no start and no overrun.
  - Stimulus: enable dropped mid-frame.
  - Required: frame completes and frame_count increments.
